// File: rtl/gray_mem_server.sv
// gray_mem_server
//   Holds one raster-order grayscale image and serves it to a downstream
//   filter one pixel per cycle.
//
//   Flow: LOAD (host streams 2^Addr_Width pixels) -> READY (filter reads
//   random addresses) -> DONE (filter finished, everything frozen) and back
//   to LOAD on restart.
//
//   Parameters
//     In_Width   : pixel width
//     Addr_Width : pixel address width, address = {row, col}, each half wide
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset (pixel store not cleared)
//     load_valid in   host pixel write strobe
//     load_data  in   host pixel, raster order
//     load_ready out  high while in LOAD
//     gray_ready out  high while in READY
//     gray_req   in   filter read request
//     gray_addr  in   filter read address
//     gray_data  out  read data, one cycle after an accepted request
//     finish     in   filter done (READY -> DONE)
//     restart    in   DONE -> LOAD
//     rd_count   out  number of served reads, saturating
//
//   Build option
//     GRAY_ZERO_BORDER_EN : served reads on the outermost row/column of the
//                           image return 0 instead of the stored pixel.
module gray_mem_server #(
  parameter int In_Width   = 8,
  parameter int Addr_Width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [In_Width-1:0]   load_data,
  output logic                  load_ready,
  output logic                  gray_ready,
  input  logic                  gray_req,
  input  logic [Addr_Width-1:0] gray_addr,
  output logic [In_Width-1:0]   gray_data,
  input  logic                  finish,
  input  logic                  restart,
  output logic [Addr_Width:0]   rd_count
);

  localparam int Depth = 2 ** Addr_Width;
  localparam int Half  = Addr_Width / 2;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [Addr_Width-1:0] r_load_ptr;
  logic [Addr_Width:0]   r_rd_count;
  logic [In_Width-1:0]   r_gray_data_p1;
  logic [In_Width-1:0]   r_mem [0:Depth-1];

  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [In_Width-1:0]   w_rd_pix;

`ifdef GRAY_ZERO_BORDER_EN
  // True when the address lies on the first/last row or first/last column.
  function automatic logic is_border(input logic [Addr_Width-1:0] a);
    logic [Addr_Width-Half-1:0] row;
    logic [Half-1:0]            col;
    row = a[Addr_Width-1:Half];
    col = a[Half-1:0];
    return (row == '0) || (row == '1) || (col == '0) || (col == '1);
  endfunction
`endif

  // Writes are blocked while rst is held so a reset mid-load cannot
  // scribble on the store.
  assign w_wr_en = (r_state == ST_LOAD) && load_valid && !rst;
  assign w_rd_en = (r_state == ST_READY) && gray_req;

`ifdef GRAY_ZERO_BORDER_EN
  assign w_rd_pix = is_border(gray_addr) ? '0 : r_mem[gray_addr];
`else
  assign w_rd_pix = r_mem[gray_addr];
`endif

  // Pixel store: no reset, contents survive rst and restart.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_load_ptr] <= load_data;
    end
  end

  // Control FSM, read counter and read data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_LOAD;
      r_load_ptr     <= '0;
      r_rd_count     <= '0;
      r_gray_data_p1 <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (load_valid) begin
            r_load_ptr <= r_load_ptr + {{(Addr_Width-1){1'b0}}, 1'b1};
            if (r_load_ptr == '1) begin
              r_state <= ST_READY;
            end
          end
        end
        ST_READY: begin
          // A request in the same cycle as finish is still served.
          if (w_rd_en) begin
            r_gray_data_p1 <= w_rd_pix;
            if (r_rd_count != '1) begin
              r_rd_count <= r_rd_count + {{Addr_Width{1'b0}}, 1'b1};
            end
          end
          if (finish) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (restart) begin
            r_state    <= ST_LOAD;
            r_load_ptr <= '0;
            r_rd_count <= '0;
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign load_ready = (r_state == ST_LOAD);
  assign gray_ready = (r_state == ST_READY);
  assign gray_data  = r_gray_data_p1;
  assign rd_count   = r_rd_count;

endmodule

// File: tb/tb_gray_mem_server.sv
// Directed bench for gray_mem_server, built with an 8-bit address
// ({row[7:4], col[3:0]}) so that full image loads stay short.
module tb_gray_mem_server;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          finish;
  logic          restart;
  logic [AW:0]   rd_count;

  int n_pass;
  int n_total;

  gray_mem_server #(
    .In_Width   (DW),
    .Addr_Width (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .finish     (finish),
    .restart    (restart),
    .rd_count   (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image content: row ^ col, optionally xor'ed with a per-image key.
  function automatic logic [7:0] pix(input logic [7:0] a, input logic [7:0] key);
    return {4'h0, a[7:4] ^ a[3:0]} ^ key;
  endfunction

  // Value the filter should see for a served read of address a.
  function automatic logic [7:0] served(input logic [7:0] a, input logic [7:0] v);
`ifdef GRAY_ZERO_BORDER_EN
    if (a[7:4] == 4'h0 || a[7:4] == 4'hF || a[3:0] == 4'h0 || a[3:0] == 4'hF)
      return 8'h00;
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full image load with one idle bubble; finish is held high for most of
  // the load (must be ignored in LOAD) and gray_req is left as the caller set it.
  task automatic load_image(input logic [7:0] key);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = i[7:0];
      if (i == 50) begin
        load_valid = 1'b0;
        load_data  = 8'hEE;
        tick();
      end
      finish     = (i < 200);
      load_valid = 1'b1;
      load_data  = pix(a, key);
      tick();
      if (i == 254) begin
        chk("load_gray_ready_before_last", gray_ready, 0);
        chk("load_ready_before_last", load_ready, 1);
      end
    end
    chk("gray_ready_after_last", gray_ready, 1);
    chk("load_ready_after_last", load_ready, 0);
    finish = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    gray_req  = 1'b1;
    gray_addr = a;
    tick();
    chk(tag, gray_data, exp);
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    gray_req   = 1'b0;
    gray_addr  = '0;
    finish     = 1'b0;
    restart    = 1'b0;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_gray_ready", gray_ready, 0);
    chk("rst_gray_data", gray_data, 0);
    chk("rst_rd_count", rd_count, 0);
    tick();
    tick();
    rst = 1'b0;

    // Partial load, then reset mid-load
    for (int i = 0; i < 100; i++) begin
      load_valid = 1'b1;
      load_data  = 8'hAA;
      tick();
    end
    chk("partial_gray_ready", gray_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("midload_rst_load_ready", load_ready, 1);
    chk("midload_rst_gray_data", gray_data, 0);
    load_valid = 1'b0;
    tick();
    rst = 1'b0;

    // Full load; gray_req held high in LOAD must be ignored
    gray_req  = 1'b1;
    gray_addr = 8'h12;
    load_image(8'h00);
    chk("load_req_ignored_count", rd_count, 0);
    chk("load_req_ignored_data", gray_data, 0);

    // READY: load_valid ignored, restart ignored, back-to-back reads
    load_valid = 1'b1;
    load_data  = 8'hEE;
    rd("rd_0x12", 8'h12, 8'h03);
    chk("rd_count_1", rd_count, 1);
    restart = 1'b1;
    rd("rd_0x23", 8'h23, 8'h01);
    restart = 1'b0;
    chk("restart_in_ready_ignored", gray_ready, 1);
    rd("rd_0x34", 8'h34, 8'h07);
    chk("rd_count_3", rd_count, 3);

    gray_req   = 1'b0;
    load_valid = 1'b0;
    gray_addr  = 8'h00;
    tick();
    tick();
    chk("hold_gray_data", gray_data, 8'h07);
    chk("hold_rd_count", rd_count, 3);

    rd("rd_0x00", 8'h00, served(8'h00, pix(8'h00, 8'h00)));
    rd("rd_0x0F", 8'h0F, served(8'h0F, pix(8'h0F, 8'h00)));
    rd("rd_0x55", 8'h55, 8'h00);
    rd("rd_0x56", 8'h56, 8'h03);
    chk("rd_count_7", rd_count, 7);

    // Long back-to-back sweep drives rd_count into saturation
    for (int i = 0; i < 520; i++) begin
      logic [7:0] a;
      a = i[7:0];
      rd("sweep", a, served(a, pix(a, 8'h00)));
    end
    chk("rd_count_saturated", rd_count, 9'h1FF);
    rd("rd_0x23_sat", 8'h23, 8'h01);
    chk("rd_count_still_sat", rd_count, 9'h1FF);

    // finish with a request in the same cycle: request still served
    finish = 1'b1;
    rd("rd_with_finish", 8'h13, 8'h02);
    finish = 1'b0;
    chk("done_gray_ready", gray_ready, 0);
    chk("done_load_ready", load_ready, 0);

    // DONE: requests and load strobes ignored, outputs frozen
    gray_req   = 1'b1;
    gray_addr  = 8'h34;
    load_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("done_gray_data_frozen", gray_data, 8'h02);
    chk("done_rd_count_frozen", rd_count, 9'h1FF);
    load_valid = 1'b0;

    // restart: back to LOAD, counter cleared, data kept
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_load_ready", load_ready, 1);
    chk("restart_gray_ready", gray_ready, 0);
    chk("restart_rd_count", rd_count, 0);
    chk("restart_gray_data_kept", gray_data, 8'h02);

    // Second image, served correctly
    load_image(8'h5A);
    chk("img2_rd_count_0", rd_count, 0);
    rd("img2_rd_0x12", 8'h12, served(8'h12, pix(8'h12, 8'h5A)));
    rd("img2_rd_0x56", 8'h56, served(8'h56, pix(8'h56, 8'h5A)));
    rd("img2_rd_0xF0", 8'hF0, served(8'hF0, pix(8'hF0, 8'h5A)));
    rd("img2_rd_0x99", 8'h99, served(8'h99, pix(8'h99, 8'h5A)));
    chk("img2_rd_count_4", rd_count, 4);

    // Reset in the middle of reading
    gray_req = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midread_rst_gray_data", gray_data, 0);
    chk("midread_rst_rd_count", rd_count, 0);
    chk("midread_rst_gray_ready", gray_ready, 0);
    chk("midread_rst_load_ready", load_ready, 1);
    gray_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gray_mem_server.md
GRAY_MEM_SERVER -- requirements
Module: gray_mem_server

Interface
REQ-001 SHALL have parameters: In_Width, default 8, pixel width; Addr_Width, default 16, pixel address width ({row[15:8], col[7:0]}).
REQ-002 SHALL have ports: clk  input  1  clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: load_valid  input  1  host pixel write strobe.
REQ-005 SHALL have port: load_data  input  In_Width  host pixel, raster order.
REQ-006 SHALL have port: load_ready  output  1  high while image load is accepted.
REQ-007 SHALL have port: gray_ready  output  1  image resident, filter may start.
REQ-008 SHALL have port: gray_req  input  1  filter read request, one pixel per cycle.
REQ-009 SHALL have port: gray_addr  input  Addr_Width  filter read address.
REQ-010 SHALL have port: gray_data  output  In_Width  read data, registered.
REQ-011 SHALL have port: finish  input  1  filter done indication (level).
REQ-012 SHALL have port: restart  input  1  return from DONE to LOAD.
REQ-013 SHALL have port: rd_count  output  Addr_Width+1  number of served reads, saturating.

Function
REQ-014 SHALL hold a 2^Addr_Width x In_Width pixel store and a 3-state FSM: LOAD, READY, DONE.
REQ-015 LOAD: load_ready=1; each cycle with load_valid=1 SHALL write load_data to mem[load_ptr] and increment load_ptr.
REQ-016 Write at load_ptr=2^Addr_Width-1 SHALL move FSM to READY next cycle; load_ptr wraps to 0.
REQ-017 READY: gray_ready=1 combinationally from state; load_ready=0; load_valid ignored.
REQ-018 READY with gray_req=1 SHALL register mem[gray_addr] onto gray_data at the next rising edge (latency exactly 1 cycle, back-to-back every cycle).
REQ-019 gray_data SHALL hold its last value on cycles with no accepted request.
REQ-020 Each accepted request SHALL increment rd_count; rd_count saturates at all-ones, no wrap.
REQ-021 READY with finish=1 SHALL move to DONE next cycle; a gray_req in that same cycle is still served.
REQ-022 DONE: gray_ready=0, load_ready=0, gray_req and load_valid ignored, gray_data and rd_count frozen.
REQ-023 DONE with restart=1 SHALL move to LOAD, clearing load_ptr and rd_count; gray_data unchanged.
REQ-024 gray_req in LOAD SHALL be ignored (no data update, no count).
REQ-025 restart outside DONE and finish outside READY SHALL have no effect.

Reset
REQ-026 rst=1 SHALL force FSM=LOAD, load_ptr=0, rd_count=0, gray_data=0, load_ready=1, gray_ready=0 immediately, including mid-load or mid-read.
REQ-027 Pixel store contents SHALL NOT be cleared by reset; a full reload is required after reset.

Configuration
REQ-028 With macro GRAY_ZERO_BORDER_EN defined, a served read whose row or col equals 0 or 2^(Addr_Width/2)-1 SHALL return 0 on gray_data (still counted).
REQ-029 Without GRAY_ZERO_BORDER_EN, every served read SHALL return the stored pixel.

Verification
REQ-030 Load 65536 pixels value (addr[7:0]^addr[15:8]) -> gray_ready rises the cycle after the last write; load_ready falls same edge.
REQ-031 READY, gray_req=1 with addresses 0x0102, 0x0203, 0x0304 on consecutive cycles -> gray_data 0x03, 0x01, 0x07 one cycle after each; rd_count=3.
REQ-032 finish=1 with gray_req=1 same cycle addr 0x1010 -> gray_data 0x00 served, state DONE, gray_ready=0, later reqs leave rd_count unchanged.
REQ-033 rst pulse after 1000 loaded pixels -> load_ptr=0, gray_data=0; reload of 65536 pixels required before gray_ready.
REQ-034 GRAY_ZERO_BORDER_EN defined, read addr 0x00FF and 0x0505 -> gray_data 0x00 then 0x00 (pixel 0x05^0x05); addr 0x0506 -> 0x03.
REQ-035 DONE, restart=1 -> LOAD, rd_count=0, load_ready=1; new image loads and is served correctly.
